// File: rtl/tiny1_irq_ctrl.sv
// Interrupt controller: synchronised rising-edge sources, mask, one interrupt at a time sequenced by irqack.
// irq and bus_data_o are registered (read data one cycle after address); no backpressure, edges never dropped.
module tiny1_irq_ctrl #(
    parameter int          NSRC      = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFFF0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_i,
    output logic            irq,
    input  logic            irqack,
    input  logic [15:0]     bus_addr,
    input  logic [15:0]     bus_data_i,
    input  logic            bus_wr,
    input  logic            bus_rd,
    output logic [15:0]     bus_data_o,
    output logic            bus_sel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COOL   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NSRC-1:0] s1;
    logic [NSRC-1:0] s2;
    logic [NSRC-1:0] src_edge;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] pending_nxt;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] masked;
    logic [NSRC-1:0] win_onehot;
    logic [NSRC-1:0] wr_bits;
    logic [NSRC-1:0] clr_bits;
    logic [NSRC-1:0] set_bits;
    logic [3:0]      win_idx;
    logic [3:0]      cause_idx;
    logic            cause_vld;
    logic            irqack_q;
    logic            any_masked;
    logic            capture;
    logic            irq_nxt;
    logic            wr_pend;
    logic            wr_mask;
    logic            wr_swset;
    logic [15:0]     rd_mux;
    logic            unused_bits;

    assign bus_sel  = (bus_addr[15:2] == BASE_ADDR[15:2]);
    assign wr_pend  = bus_sel & bus_wr & (bus_addr[1:0] == 2'd0);
    assign wr_mask  = bus_sel & bus_wr & (bus_addr[1:0] == 2'd1);
    assign wr_swset = bus_sel & bus_wr & (bus_addr[1:0] == 2'd3);
    assign wr_bits  = bus_data_i[NSRC-1:0];

    assign unused_bits = ^{bus_data_i, BASE_ADDR[1:0]};

    assign src_edge   = s1 & ~s2;
    assign masked     = pending & mask;
    assign any_masked = |masked;
    // Isolate the lowest set bit: lowest index wins arbitration.
    assign win_onehot = masked & (~masked + NSRC'(1));

    always_comb begin
        win_idx = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (masked[i]) begin
                win_idx = 4'(i);
            end
        end
    end

    assign capture = (state == IDLE) & irq & irqack;

    // An ack level left high across reset is not a fresh ack; irqack_q resets high so only
    // a real rise (or irq being reasserted) moves IDLE on.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (irqack && (irq || !irqack_q)) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!irqack) begin
                    state_nxt = COOL;
                end
            end
            COOL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign irq_nxt = (state_nxt == IDLE) & any_masked;

    // Sets are applied after clears so a coincident set always wins.
    assign clr_bits    = (wr_pend ? wr_bits : '0) | ((capture & any_masked) ? win_onehot : '0);
    assign set_bits    = src_edge | (wr_swset ? wr_bits : '0);
    assign pending_nxt = (pending & ~clr_bits) | set_bits;

    always_comb begin
        rd_mux = 16'h0000;
        case (bus_addr[1:0])
            2'd0:    rd_mux[NSRC-1:0] = pending;
            2'd1:    rd_mux[NSRC-1:0] = mask;
            2'd2:    rd_mux = {cause_vld, 11'd0, cause_idx};
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            pending    <= '0;
            mask       <= '0;
            cause_vld  <= 1'b0;
            cause_idx  <= 4'd0;
            state      <= IDLE;
            irq        <= 1'b0;
            irqack_q   <= 1'b1;
            bus_data_o <= 16'h0000;
        end else begin
            s1       <= src_i;
            s2       <= s1;
            pending  <= pending_nxt;
            state    <= state_nxt;
            irq      <= irq_nxt;
            irqack_q <= irqack;
            if (wr_mask) begin
                mask <= wr_bits;
            end
            // A capture with nothing enabled records a spurious (all-zero) cause.
            if (capture) begin
                cause_vld <= any_masked;
                cause_idx <= any_masked ? win_idx : 4'd0;
            end
            bus_data_o <= (bus_sel & bus_rd) ? rd_mux : 16'h0000;
        end
    end

endmodule

// File: tb/tb_tiny1_irq_ctrl.sv
// Directed bench for tiny1_irq_ctrl: inputs change and outputs are sampled on the falling clock edge.
module tb_tiny1_irq_ctrl;

    localparam logic [15:0] BASE = 16'hFFF0;

    logic        clk;
    logic        rst;
    logic [7:0]  src_i;
    logic        irq;
    logic        irqack;
    logic [15:0] bus_addr;
    logic [15:0] bus_data_i;
    logic        bus_wr;
    logic        bus_rd;
    logic [15:0] bus_data_o;
    logic        bus_sel;

    int checks   = 0;
    int failures = 0;

    tiny1_irq_ctrl #(.NSRC(8), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_i      (src_i),
        .irq        (irq),
        .irqack     (irqack),
        .bus_addr   (bus_addr),
        .bus_data_i (bus_data_i),
        .bus_wr     (bus_wr),
        .bus_rd     (bus_rd),
        .bus_data_o (bus_data_o),
        .bus_sel    (bus_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] off, input logic [15:0] d);
        bus_addr   = BASE | {14'd0, off};
        bus_data_i = d;
        bus_wr     = 1'b1;
        tick();
        bus_wr     = 1'b0;
        bus_addr   = 16'h0000;
        bus_data_i = 16'h0000;
    endtask

    task automatic rdchk(input string tag, input logic [1:0] off, input logic [15:0] exp);
        bus_addr = BASE | {14'd0, off};
        bus_rd   = 1'b1;
        tick();
        check(tag, bus_data_o, exp);
        bus_rd   = 1'b0;
        bus_addr = 16'h0000;
    endtask

    initial begin
        rst = 1'b1; src_i = 8'h00; irqack = 1'b0;
        bus_addr = 16'h0000; bus_data_i = 16'h0000; bus_wr = 1'b0; bus_rd = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and address decode
        check("rst_irq", {15'd0, irq}, 16'h0000);
        check("rst_rdata", bus_data_o, 16'h0000);
        check("sel_off", {15'd0, bus_sel}, 16'h0000);
        bus_addr = 16'hFFF3; #1;
        check("sel_fff3", {15'd0, bus_sel}, 16'h0001);
        bus_addr = 16'hFFF4; #1;
        check("sel_fff4", {15'd0, bus_sel}, 16'h0000);
        bus_addr = 16'h0000;
        rdchk("rst_pending", 2'd0, 16'h0000);
        rdchk("rst_mask", 2'd1, 16'h0000);
        rdchk("rst_cause", 2'd2, 16'h0000);

        // Single source: edge -> pending -> irq -> capture
        wr(2'd1, 16'h0004);
        rdchk("t1_mask", 2'd1, 16'h0004);
        tick();
        check("t1_rdata_idle", bus_data_o, 16'h0000);
        src_i = 8'h04;
        tick();
        check("t1_irq_e1", {15'd0, irq}, 16'h0000);
        tick();
        check("t1_irq_e2", {15'd0, irq}, 16'h0000);
        tick();
        check("t1_irq_e3", {15'd0, irq}, 16'h0001);
        src_i = 8'h00;
        rdchk("t1_pending", 2'd0, 16'h0004);
        irqack = 1'b1;
        tick();
        check("t1_irq_cap", {15'd0, irq}, 16'h0000);
        rdchk("t1_cause", 2'd2, 16'h8002);
        rdchk("t1_pend_cap", 2'd0, 16'h0000);
        irqack = 1'b0;
        tick(); tick();

        // Two simultaneous sources: lowest index first, COOL gap, then the next
        wr(2'd1, 16'h00FF);
        src_i = 8'h22;
        tick(); tick(); tick();
        check("t2_irq", {15'd0, irq}, 16'h0001);
        src_i = 8'h00;
        irqack = 1'b1;
        tick();
        check("t2_irq_cap", {15'd0, irq}, 16'h0000);
        rdchk("t2_cause1", 2'd2, 16'h8001);
        rdchk("t2_pending", 2'd0, 16'h0020);
        check("t2_irq_active", {15'd0, irq}, 16'h0000);
        irqack = 1'b0;
        tick();
        check("t2_irq_cool", {15'd0, irq}, 16'h0000);
        tick();
        check("t2_irq_rearm", {15'd0, irq}, 16'h0001);
        irqack = 1'b1;
        bus_addr = BASE | 16'h0002; bus_rd = 1'b1;
        tick();
        check("t2_cause_precap", bus_data_o, 16'h8001);
        check("t2_irq_cap2", {15'd0, irq}, 16'h0000);
        bus_rd = 1'b0; bus_addr = 16'h0000;
        rdchk("t2_cause2", 2'd2, 16'h8005);
        rdchk("t2_pend2", 2'd0, 16'h0000);
        irqack = 1'b0;
        tick(); tick();

        // Masked source stays pending; enabling it raises irq one edge after the write
        wr(2'd1, 16'h0000);
        src_i = 8'h08;
        tick(); tick();
        src_i = 8'h00;
        tick();
        check("t3_irq_masked", {15'd0, irq}, 16'h0000);
        rdchk("t3_pending", 2'd0, 16'h0008);
        wr(2'd1, 16'h0008);
        check("t3_irq_wr_edge", {15'd0, irq}, 16'h0000);
        tick();
        check("t3_irq_after", {15'd0, irq}, 16'h0001);
        irqack = 1'b1;
        tick();
        rdchk("t3_cause", 2'd2, 16'h8003);
        irqack = 1'b0;
        tick(); tick();

        // Set beats clear, W1C, SWSET, read-only CAUSE
        wr(2'd1, 16'h0000);
        src_i = 8'h01;
        tick();
        wr(2'd0, 16'h0001);
        src_i = 8'h00;
        rdchk("t4_set_wins", 2'd0, 16'h0001);
        wr(2'd0, 16'h0001);
        rdchk("t4_w1c", 2'd0, 16'h0000);
        wr(2'd3, 16'h0080);
        rdchk("t4_swset", 2'd0, 16'h0080);
        rdchk("t4_swset_rd0", 2'd3, 16'h0000);
        wr(2'd0, 16'h00FF);
        wr(2'd2, 16'hFFFF);
        rdchk("t4_cause_ro", 2'd2, 16'h8003);
        rdchk("t4_pend_clr", 2'd0, 16'h0000);

        // Mask removed under a raised irq: spurious capture
        wr(2'd3, 16'h0010);
        wr(2'd1, 16'h0010);
        tick();
        check("t5_irq", {15'd0, irq}, 16'h0001);
        wr(2'd1, 16'h0000);
        check("t5_irq_held", {15'd0, irq}, 16'h0001);
        irqack = 1'b1;
        tick();
        check("t5_irq_cap", {15'd0, irq}, 16'h0000);
        rdchk("t5_cause_spur", 2'd2, 16'h0000);
        rdchk("t5_pend_kept", 2'd0, 16'h0010);
        wr(2'd1, 16'h0010);
        tick();
        check("t5_active_hold", {15'd0, irq}, 16'h0000);

        // Reset while ACTIVE with irqack still high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_irq_rst", {15'd0, irq}, 16'h0000);
        check("t6_rdata_rst", bus_data_o, 16'h0000);
        rdchk("t6_pending", 2'd0, 16'h0000);
        rdchk("t6_mask", 2'd1, 16'h0000);
        rdchk("t6_cause", 2'd2, 16'h0000);
        tick(); tick();
        check("t6_irq_idle", {15'd0, irq}, 16'h0000);
        wr(2'd1, 16'h0001);
        src_i = 8'h01;
        tick(); tick();
        src_i = 8'h00;
        rdchk("t6_cause_nocap", 2'd2, 16'h0000);
        check("t6_irq_new", {15'd0, irq}, 16'h0001);
        tick();
        check("t6_irq_cap", {15'd0, irq}, 16'h0000);
        rdchk("t6_cause_cap", 2'd2, 16'h8000);
        rdchk("t6_pend_cap", 2'd0, 16'h0000);
        irqack = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
